rotate_switch_pipe: RTL and testbench

Pipelined, parametrised lane-rotation switch between the NUM_PE processing-element lanes and the memory-group ports of the HE datapath. Each accepted transaction carries NUM_PE words plus a per-transaction rotation amount and direction. The rotation is done as a log2(NUM_PE)-stage barrel network, one registered stage per bit of the shift amount. Every stage has valid/ready flow control, so the block sustains one transaction per cycle and absorbs downstream backpressure without losing data.

---
 rtl/switch_pkg.sv | 24 ++
 rtl/rotate_stage.sv | 78 +++++++
 rtl/rotate_switch_pipe.sv | 105 ++++++++++
 tb/tb_rotate_switch_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and the lane-index helper for the rotate switch.
package switch_pkg;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam int PERF_CNT_W = 32;

  // Source lane feeding output lane j after rotating by amt.
  function automatic int rot_idx(
    input int   j,
    input int   amt,
    input dir_e dir,
    input int   n
  );
    int a;
    a = amt % n;
    if (dir == DIR_LEFT) return (j + a) % n;
    return (j + n - a) % n;
  endfunction

endpackage

// File: rtl/rotate_stage.sv
// One registered barrel stage: rotates by SHIFT when shamt[BIT] is set.
module rotate_stage
  import switch_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PE     = 8,
  parameter int LOG_PE     = $clog2(NUM_PE),
  parameter int SHIFT      = 1,
  parameter int BIT        = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic                              in_dir,
  input  logic [LOG_PE-1:0]                 in_shamt,
  input  logic [NUM_PE-1:0][DATA_WIDTH-1:0] in_data,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic                              out_dir,
  output logic [LOG_PE-1:0]                 out_shamt,
  output logic [NUM_PE-1:0][DATA_WIDTH-1:0] out_data
);

  logic                              valid_q, valid_d;
  logic                              dir_q, dir_d;
  logic [LOG_PE-1:0]                 shamt_q, shamt_d;
  logic [NUM_PE-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_PE-1:0][DATA_WIDTH-1:0] rot_d;
  logic                              accept;

  assign accept = !valid_q || out_ready;

  for (genvar j = 0; j < NUM_PE; j++) begin : g_lane
    localparam int SRC_L = rot_idx(j, SHIFT, DIR_LEFT, NUM_PE);
    localparam int SRC_R = rot_idx(j, SHIFT, DIR_RIGHT, NUM_PE);
    assign rot_d[j] = !in_shamt[BIT] ? in_data[j]
                    : in_dir         ? in_data[SRC_R]
                    :                  in_data[SRC_L];
  end

  always_comb begin
    valid_d = valid_q;
    dir_d   = dir_q;
    shamt_d = shamt_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = in_valid;
      if (in_valid) begin
        dir_d   = in_dir;
        shamt_d = in_shamt;
        data_d  = rot_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      dir_q   <= 1'b0;
      shamt_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      dir_q   <= dir_d;
      shamt_q <= shamt_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_dir   = dir_q;
  assign out_shamt = shamt_q;
  assign out_data  = data_q;

endmodule

// File: rtl/rotate_switch_pipe.sv
// Pipelined lane-rotation switch, one barrel stage per shamt bit.
// Perf counters are built only when SWITCH_PERF_EN is defined.
module rotate_switch_pipe
  import switch_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PE     = 8,
  parameter int LOG_PE     = $clog2(NUM_PE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LOG_PE-1:0]     in_shamt,
  input  logic                  in_dir,
  input  logic [DATA_WIDTH-1:0] in_data [0:NUM_PE-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data [0:NUM_PE-1],
  output logic [PERF_CNT_W-1:0] perf_xfers,
  output logic [PERF_CNT_W-1:0] perf_stalls
);

  logic                              vld_c [LOG_PE+1];
  logic                              rdy_c [LOG_PE+1];
  logic                              dir_c [LOG_PE+1];
  logic [LOG_PE-1:0]                 sh_c  [LOG_PE+1];
  logic [NUM_PE-1:0][DATA_WIDTH-1:0] dat_c [LOG_PE+1];
  logic                              unused_side;

  assign vld_c[0] = in_valid;
  assign dir_c[0] = in_dir;
  assign sh_c[0]  = in_shamt;

  for (genvar j = 0; j < NUM_PE; j++) begin : g_io
    assign dat_c[0][j] = in_data[j];
    assign out_data[j] = dat_c[LOG_PE][j];
  end

  assign rdy_c[LOG_PE] = out_ready;

  for (genvar s = 0; s < LOG_PE; s++) begin : g_stage
    assign rdy_c[s] = !vld_c[s+1] || rdy_c[s+1];

    rotate_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_PE     (NUM_PE),
      .LOG_PE     (LOG_PE),
      .SHIFT      (1 << s),
      .BIT        (s)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (vld_c[s]),
      .in_dir    (dir_c[s]),
      .in_shamt  (sh_c[s]),
      .in_data   (dat_c[s]),
      .out_ready (rdy_c[s+1]),
      .out_valid (vld_c[s+1]),
      .out_dir   (dir_c[s+1]),
      .out_shamt (sh_c[s+1]),
      .out_data  (dat_c[s+1])
    );
  end

  assign in_ready    = rdy_c[0] && rst && !flush;
  assign out_valid   = vld_c[LOG_PE];
  assign unused_side = ^{dir_c[LOG_PE], sh_c[LOG_PE]};

`ifdef SWITCH_PERF_EN
  logic [PERF_CNT_W-1:0] xfers_q, xfers_d;
  logic [PERF_CNT_W-1:0] stalls_q, stalls_d;

  // A flushed output is discarded, so it counts as neither.
  always_comb begin
    xfers_d  = xfers_q;
    stalls_d = stalls_q;
    if (!flush && out_valid) begin
      if (out_ready && xfers_q != '1)
        xfers_d = xfers_q + PERF_CNT_W'(1);
      if (!out_ready && stalls_q != '1)
        stalls_d = stalls_q + PERF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      xfers_q  <= '0;
      stalls_q <= '0;
    end else begin
      xfers_q  <= xfers_d;
      stalls_q <= stalls_d;
    end
  end

  assign perf_xfers  = xfers_q;
  assign perf_stalls = stalls_q;
`else
  assign perf_xfers  = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_rotate_switch_pipe.sv
// Directed bench for rotate_switch_pipe with an in-order scoreboard.
module tb_rotate_switch_pipe;
  import switch_pkg::*;

  localparam int DW = 64;
  localparam int NP = 8;
  localparam int LP = 3;
  localparam int W  = DW * NP;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [LP-1:0] in_shamt;
  logic          in_dir;
  logic [DW-1:0] in_data [0:NP-1];
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data [0:NP-1];
  logic [31:0]   perf_xfers;
  logic [31:0]   perf_stalls;

  always #5 clk = ~clk;

  rotate_switch_pipe #(
    .DATA_WIDTH (DW),
    .NUM_PE     (NP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_shamt    (in_shamt),
    .in_dir      (in_dir),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .perf_xfers  (perf_xfers),
    .perf_stalls (perf_stalls)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int rx_cnt = 0;
  int acc_cnt = 0;
  int rx0, acc0;
  logic [31:0] m_xfers  = '0;
  logic [31:0] m_stalls = '0;
  logic [W-1:0] exp_q [$];

  function automatic logic [W-1:0] pack(input logic [DW-1:0] a [0:NP-1]);
    logic [W-1:0] r;
    for (int j = 0; j < NP; j++) r[j*DW +: DW] = a[j[2:0]];
    return r;
  endfunction

  function automatic logic [W-1:0] lanes(input int v [NP]);
    logic [W-1:0] r;
    for (int j = 0; j < NP; j++) r[j*DW +: DW] = DW'(v[j[2:0]]);
    return r;
  endfunction

  function automatic logic [W-1:0] model(
    input logic [DW-1:0] d [0:NP-1],
    input logic [LP-1:0] sh,
    input logic          dr
  );
    logic [W-1:0] r;
    int idx;
    for (int j = 0; j < NP; j++) begin
      idx = rot_idx(j, int'(sh), dir_e'(dr), NP);
      r[j*DW +: DW] = d[idx[2:0]];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_perf(input string tag);
`ifdef SWITCH_PERF_EN
    chk({tag, "_xfers"}, perf_xfers, m_xfers);
    chk({tag, "_stalls"}, perf_stalls, m_stalls);
`else
    chk({tag, "_xfers"}, perf_xfers, 0);
    chk({tag, "_stalls"}, perf_stalls, 0);
`endif
  endtask

  // Bookkeeping at the falling edge, then advance past the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (out_valid && out_ready) begin
      rx_cnt++;
      if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
      else chk("sb_data", pack(out_data), exp_q.pop_front());
      if (rst && !flush && m_xfers != '1) m_xfers++;
    end
    if (out_valid && !out_ready && rst && !flush && m_stalls != '1)
      m_stalls++;
    if (in_valid && in_ready) begin
      acc_cnt++;
      exp_q.push_back(model(in_data, in_shamt, in_dir));
    end
    if (flush || !rst) exp_q.delete();
    if (!rst) begin
      m_xfers  = '0;
      m_stalls = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input int base);
    for (int k = 0; k < NP; k++) in_data[k[2:0]] = DW'(base + k);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; in_shamt = '0; in_dir = 1'b0;
    set_lanes(0);
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", pack(out_data), 0);
    chk("rst_xfers", perf_xfers, 0);
    chk("rst_stalls", perf_stalls, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Left rotate by 3, then latency boundary
    set_lanes(0); in_shamt = 3'd3; in_dir = 1'b0; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("lat_early", out_valid, 0);
    cyc();
    chk("lat_valid", out_valid, 1);
    chk("rotl3", pack(out_data), lanes('{3, 4, 5, 6, 7, 0, 1, 2}));

    // Right rotate by 3, then shamt 0 back to back
    in_shamt = 3'd3; in_dir = 1'b1; in_valid = 1'b1;
    cyc();
    in_shamt = 3'd0; in_dir = 1'b0;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("rotr3", pack(out_data), lanes('{5, 6, 7, 0, 1, 2, 3, 4}));
    cyc();
    chk("pass0", pack(out_data), lanes('{0, 1, 2, 3, 4, 5, 6, 7}));
    cyc(); cyc();

    // Back-to-back random stream
    rx0 = rx_cnt;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < NP; k++) in_data[k[2:0]] = {$urandom, $urandom};
      in_shamt = LP'($urandom_range(0, NP - 1));
      in_dir   = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      chk("stream_rdy", in_ready, 1);
      cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("stream_count", rx_cnt - rx0, 20);
    chk("stream_drain", exp_q.size(), 0);
    chk_perf("stream");

    // Backpressure: 10 stalled cycles with continuous input
    out_ready = 1'b0;
    acc0 = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      set_lanes(16 * (i + 1));
      in_shamt = 3'd1; in_dir = 1'b0; in_valid = 1'b1;
      cyc();
    end
    chk("stall_accepts", acc_cnt - acc0, 3);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_hold", pack(out_data),
        lanes('{17, 18, 19, 20, 21, 22, 23, 16}));
    chk_perf("stall");
    rx0 = rx_cnt;
    out_ready = 1'b1;
    set_lanes(200); in_shamt = 3'd2; in_dir = 1'b1;
    #1;
    chk("release_rdy", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("release_count", rx_cnt - rx0, 4);
    chk("release_drain", exp_q.size(), 0);

    // Flush with three in flight and a colliding input
    for (int i = 0; i < 3; i++) begin
      set_lanes(300 + 8 * i);
      in_shamt = LP'(i + 5); in_dir = 1'(i); in_valid = 1'b1;
      cyc();
    end
    flush = 1'b1;
    set_lanes(400); in_shamt = 3'd1;
    #1;
    chk("flush_rdy", in_ready, 0);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("flush_drop", out_valid, 0);
    end
    chk_perf("flush");

    // Reset mid-stream
    for (int i = 0; i < 2; i++) begin
      set_lanes(500 + 8 * i);
      in_shamt = 3'd6; in_dir = 1'b1; in_valid = 1'b1;
      cyc();
    end
    rst = 1'b0;
    #1;
    chk("midrst_rdy", in_ready, 0);
    cyc();
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", pack(out_data), 0);
    chk("midrst_xfers", perf_xfers, 0);
    chk("midrst_stalls", perf_stalls, 0);
    chk("midrst_rel_rdy", in_ready, 1);

    // Post-reset traffic, left rotate by 5
    set_lanes(0); in_shamt = 3'd5; in_dir = 1'b0; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc(); cyc();
    chk("post_rotl5", pack(out_data), lanes('{5, 6, 7, 0, 1, 2, 3, 4}));
    cyc();
    chk("post_drain", exp_q.size(), 0);
    chk_perf("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
